// File: rtl/chardisp_pkg.sv
// Shared constants, VRAM word layout and engine state encoding for the text console.
package chardisp_pkg;

  localparam int COLS       = 80;
  localparam int ROWS       = 50;
  localparam int VRAM_WORDS = COLS * ROWS;
  localparam int COLOR_LSB  = 8;
  localparam int CODE_W     = 7;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCRL_RD,
    SCRL_WR,
    CLR_LINE,
    CLR_ALL
  } state_e;

  // Packs a character cell: colour at [19:8], code at [6:0], everything else zero.
  function automatic logic [31:0] char_word(input logic [11:0] color,
                                            input logic [CODE_W-1:0] code);
    logic [31:0] w;
    w = '0;
    w[COLOR_LSB +: 12] = color;
    w[CODE_W-1:0]      = code;
    return w;
  endfunction

endpackage

// File: rtl/chardisp_arb.sv
// Host/engine VRAM multiplexer; any host access wins the bus and stalls the engine.
module chardisp_arb #(
  parameter int AW = 12
) (
  input  logic [15:0]   h_wraddr,
  input  logic [3:0]    h_byteen,
  input  logic          h_wren,
  input  logic [31:0]   h_wrdata,
  input  logic [15:0]   h_rdaddr,
  input  logic          h_rden,
  input  logic [AW-1:0] e_addr,
  input  logic          e_wren,
  input  logic          e_rden,
  input  logic [31:0]   e_wrdata,
  output logic          stall,
  output logic [15:0]   wraddr,
  output logic [3:0]    byteen,
  output logic          wren,
  output logic [31:0]   wrdata,
  output logic [15:0]   rdaddr,
  output logic          rden
);
  import chardisp_pkg::*;

  logic [15:0] e_baddr;
  assign e_baddr = 16'({e_addr, 2'b00});

  always_comb begin
    stall = h_wren | h_rden;
    if (stall) begin
      wraddr = h_wraddr;
      byteen = h_byteen;
      wren   = h_wren;
      wrdata = h_wrdata;
      rdaddr = h_rdaddr;
      rden   = h_rden;
    end else begin
      wraddr = e_baddr;
      byteen = 4'b0111;
      wren   = e_wren;
      wrdata = e_wrdata;
      rdaddr = e_baddr;
      rden   = e_rden;
    end
  end

endmodule

// File: rtl/chardisp_console.sv
// Text console engine: character stream in, VRAM cell writes out, with scroll and clear.
module chardisp_console #(
  parameter int COLS = 80,
  parameter int ROWS = 50,
  parameter int AW   = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CH_VALID,
  output logic        CH_READY,
  input  logic [7:0]  CH_DATA,
  input  logic [11:0] CH_COLOR,
  input  logic        CLR_REQ,
  output logic        BUSY,
  output logic [6:0]  CURX,
  output logic [5:0]  CURY,
  input  logic [15:0] H_WRADDR,
  input  logic [3:0]  H_BYTEEN,
  input  logic        H_WREN,
  input  logic [31:0] H_WRDATA,
  input  logic [15:0] H_RDADDR,
  input  logic        H_RDEN,
  output logic [31:0] H_RDDATA,
  output logic [15:0] WRADDR,
  output logic [3:0]  BYTEEN,
  output logic        WREN,
  output logic [31:0] WRDATA,
  output logic [15:0] RDADDR,
  output logic        RDEN,
  input  logic [31:0] RDDATA
);
  import chardisp_pkg::*;

  localparam logic [6:0]    X_LAST    = 7'(COLS - 1);
  localparam logic [5:0]    Y_LAST    = 6'(ROWS - 1);
  localparam logic [AW-1:0] ROW_WORDS = AW'(COLS);
  localparam logic [AW-1:0] SCRL_LAST = AW'(COLS * ROWS - COLS - 1);
  localparam logic [AW-1:0] W_LAST    = AW'(COLS * ROWS - 1);

  state_e              state;
  logic [6:0]          curx;
  logic [5:0]          cury;
  logic                clr_pend;
  logic [AW-1:0]       idx;
  logic                rd_pend;
  logic [31:0]         cap;
  logic [CODE_W-1:0]   code_q;
  logic [11:0]         color_q;
  logic                stall;
  logic                accept;
  logic                printable;
  logic [AW-1:0]       cur_addr;
  logic [AW-1:0]       e_addr;
  logic                e_wren;
  logic                e_rden;
  logic [31:0]         e_wrdata;

  assign CH_READY  = (state == IDLE) & ~clr_pend & ~CLR_REQ & RST;
  assign accept    = CH_VALID & CH_READY;
  assign printable = (CH_DATA >= 8'h20) && (CH_DATA <= 8'h7E);
  assign BUSY      = (state != IDLE) | clr_pend;
  assign CURX      = curx;
  assign CURY      = cury;
  assign H_RDDATA  = RDDATA;
  assign cur_addr  = AW'(cury) * ROW_WORDS + AW'(curx);

  always_comb begin
    e_addr   = idx;
    e_wren   = 1'b0;
    e_rden   = 1'b0;
    e_wrdata = '0;
    case (state)
      PUT: begin
        e_addr   = cur_addr;
        e_wren   = 1'b1;
        e_wrdata = char_word(color_q, code_q);
      end
      SCRL_RD: begin
        e_addr = idx + ROW_WORDS;
        e_rden = 1'b1;
      end
      SCRL_WR: begin
        e_wren   = 1'b1;
        // The read returns in this cycle only; later (stalled) cycles use the captured copy.
        e_wrdata = rd_pend ? RDDATA : cap;
      end
      CLR_LINE, CLR_ALL: e_wren = 1'b1;
      default: ;
    endcase
  end

  chardisp_arb #(.AW(AW)) u_arb (
    .h_wraddr (H_WRADDR),
    .h_byteen (H_BYTEEN),
    .h_wren   (H_WREN),
    .h_wrdata (H_WRDATA),
    .h_rdaddr (H_RDADDR),
    .h_rden   (H_RDEN),
    .e_addr   (e_addr),
    .e_wren   (e_wren),
    .e_rden   (e_rden),
    .e_wrdata (e_wrdata),
    .stall    (stall),
    .wraddr   (WRADDR),
    .byteen   (BYTEEN),
    .wren     (WREN),
    .wrdata   (WRDATA),
    .rdaddr   (RDADDR),
    .rden     (RDEN)
  );

  always_ff @(posedge CLK) begin
    if (rd_pend) cap <= RDDATA;
    if (accept) begin
      code_q  <= CH_DATA[CODE_W-1:0];
      color_q <= CH_COLOR;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      curx     <= '0;
      cury     <= '0;
      clr_pend <= 1'b0;
      idx      <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= 1'b0;
      if (CLR_REQ) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_pend) begin
            state    <= CLR_ALL;
            idx      <= '0;
            clr_pend <= CLR_REQ;
          end else if (accept) begin
            if (printable) begin
              state <= PUT;
            end else if (CH_DATA == 8'h0D) begin
              curx <= '0;
            end else if (CH_DATA == 8'h0A) begin
              curx <= '0;
              if (cury == Y_LAST) begin
                state <= SCRL_RD;
                idx   <= '0;
              end else begin
                cury <= cury + 6'd1;
              end
            end else if (CH_DATA == 8'h08 && curx != 7'd0) begin
              curx <= curx - 7'd1;
            end
          end
        end
        PUT: if (!stall) begin
          state <= IDLE;
          if (curx == X_LAST) begin
            curx <= '0;
            if (cury == Y_LAST) begin
              state <= SCRL_RD;
              idx   <= '0;
            end else begin
              cury <= cury + 6'd1;
            end
          end else begin
            curx <= curx + 7'd1;
          end
        end
        SCRL_RD: if (!stall) begin
          state   <= SCRL_WR;
          rd_pend <= 1'b1;
        end
        SCRL_WR: if (!stall) begin
          // idx rolls straight from the last copied word into the first word of the bottom row.
          state <= (idx == SCRL_LAST) ? CLR_LINE : SCRL_RD;
          idx   <= idx + AW'(1);
        end
        CLR_LINE: if (!stall) begin
          if (idx == W_LAST) state <= IDLE;
          else               idx   <= idx + AW'(1);
        end
        CLR_ALL: if (!stall) begin
          if (idx == W_LAST) begin
            state <= IDLE;
            curx  <= '0;
            cury  <= '0;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chardisp_console.sv
// Directed bench for chardisp_console with a behavioural VRAM model.
module tb_chardisp_console;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CH_VALID;
  logic        CH_READY;
  logic [7:0]  CH_DATA;
  logic [11:0] CH_COLOR;
  logic        CLR_REQ;
  logic        BUSY;
  logic [6:0]  CURX;
  logic [5:0]  CURY;
  logic [15:0] H_WRADDR;
  logic [3:0]  H_BYTEEN;
  logic        H_WREN;
  logic [31:0] H_WRDATA;
  logic [15:0] H_RDADDR;
  logic        H_RDEN;
  logic [31:0] H_RDDATA;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WRDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDDATA;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  chardisp_console #(.COLS(80), .ROWS(50), .AW(12)) dut (
    .CLK(CLK), .RST(RST), .CH_VALID(CH_VALID), .CH_READY(CH_READY),
    .CH_DATA(CH_DATA), .CH_COLOR(CH_COLOR), .CLR_REQ(CLR_REQ), .BUSY(BUSY),
    .CURX(CURX), .CURY(CURY), .H_WRADDR(H_WRADDR), .H_BYTEEN(H_BYTEEN),
    .H_WREN(H_WREN), .H_WRDATA(H_WRDATA), .H_RDADDR(H_RDADDR), .H_RDEN(H_RDEN),
    .H_RDDATA(H_RDDATA), .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN),
    .WRDATA(WRDATA), .RDADDR(RDADDR), .RDEN(RDEN), .RDDATA(RDDATA)
  );

  // VRAM model: byte-enabled writes, one-cycle read latency, backdoor row-index fill.
  logic [31:0] mem [0:4095];
  logic [31:0] rd_q;
  int fill_req  = 0;
  int fill_done = 0;
  assign RDDATA = rd_q;

  always @(posedge CLK) begin
    if (fill_req != fill_done) begin
      for (int i = 0; i < 4096; i++) mem[i] = (i < 4000) ? 32'(i / 80) : 32'h0;
      fill_done = fill_req;
    end
    if (WREN)
      for (int b = 0; b < 4; b++)
        if (BYTEEN[b]) mem[WRADDR[13:2]][b*8 +: 8] = WRDATA[b*8 +: 8];
    if (RDEN) rd_q <= mem[RDADDR[13:2]];
  end

  typedef struct {
    logic [7:0]  ch;
    logic [11:0] col;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [6:0]  x;
    logic [5:0]  y;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_fill();
    fill_req++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // Waits for CH_READY, presents one character, returns at the negedge after the accept edge.
  task automatic send_char(input logic [7:0] ch, input logic [11:0] col);
    int k;
    k = 0;
    while (!CH_READY && k < 20000) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 20000) check("ch_ready_wait", {31'b0, CH_READY}, 32'd1);
    CH_VALID = 1'b1;
    CH_DATA  = ch;
    CH_COLOR = col;
    @(negedge CLK);
    CH_VALID = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    send_char(v.ch, v.col);
    check($sformatf("v%0d_wren", n), {31'b0, WREN}, {31'b0, v.wr});
    if (v.wr) begin
      check($sformatf("v%0d_addr", n), {16'b0, WRADDR}, {16'b0, v.addr});
      check($sformatf("v%0d_data", n), WRDATA, v.data);
      check($sformatf("v%0d_byteen", n), {28'b0, BYTEEN}, 32'h7);
      @(negedge CLK);
    end
    check($sformatf("v%0d_ready", n), {31'b0, CH_READY}, 32'd1);
    check($sformatf("v%0d_curx", n), {25'b0, CURX}, {25'b0, v.x});
    check($sformatf("v%0d_cury", n), {26'b0, CURY}, {26'b0, v.y});
  endtask

  // Triggers a scroll with an LF from row 49, optionally with host writes every third cycle.
  task automatic do_scroll(input bit host, input int tag);
    int busy, hcnt, perr, cyc, hk, bad;
    logic [11:0] last_w;
    logic [31:0] last_d, exp;
    busy = 0; hcnt = 0; perr = 0; cyc = 0; hk = 0; bad = 0;
    last_w = '0; last_d = '0;
    send_char(8'h0A, 12'h000);
    while (BUSY && busy < 30000) begin
      busy++;
      if (H_WREN) begin
        hcnt++;
        last_w = H_WRADDR[13:2];
        last_d = H_WRDATA;
        if (WRADDR !== H_WRADDR || WRDATA !== H_WRDATA || BYTEEN !== H_BYTEEN ||
            WREN !== 1'b1 || RDEN !== 1'b0) perr++;
      end
      cyc++;
      if (host && (cyc % 3 == 0)) begin
        H_WREN   = 1'b1;
        H_BYTEEN = 4'hF;
        H_WRADDR = 16'((4000 + hk % 96) * 4);
        H_WRDATA = 32'hA5A50000 | 32'(hk);
        hk++;
      end else begin
        H_WREN = 1'b0;
      end
      @(negedge CLK);
    end
    H_WREN = 1'b0;
    check($sformatf("scr%0d_cycles", tag), busy, 7920 + hcnt);
    check($sformatf("scr%0d_passthru_errs", tag), perr, 0);
    if (host) begin
      check($sformatf("scr%0d_host_seen", tag), {31'b0, hcnt > 1000}, 32'd1);
      check($sformatf("scr%0d_host_landed", tag), mem[last_w], last_d);
    end
    for (int i = 0; i < 4000; i++) begin
      exp = (i < 3920) ? 32'(i / 80 + 1) : 32'h0;
      if (mem[i] !== exp) bad++;
    end
    check($sformatf("scr%0d_image_bad_words", tag), bad, 0);
    check($sformatf("scr%0d_w0", tag), mem[0], 32'd1);
    check($sformatf("scr%0d_w3919", tag), mem[3919], 32'd49);
    check($sformatf("scr%0d_w3920", tag), mem[3920], 32'd0);
    check($sformatf("scr%0d_curx", tag), {25'b0, CURX}, 32'd0);
    check($sformatf("scr%0d_cury", tag), {26'b0, CURY}, 32'd49);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy, bad, k;
    RST = 1'b0; CH_VALID = 1'b0; CH_DATA = '0; CH_COLOR = '0; CLR_REQ = 1'b0;
    H_WRADDR = '0; H_BYTEEN = '0; H_WREN = 1'b0; H_WRDATA = '0;
    H_RDADDR = '0; H_RDEN = 1'b0;

    vecs[0]  = '{8'h41, 12'hF00, 1'b1, 16'h0000, 32'h000F0041, 7'd1, 6'd0};
    vecs[1]  = '{8'h62, 12'h0AB, 1'b1, 16'h0004, 32'h0000AB62, 7'd2, 6'd0};
    vecs[2]  = '{8'h0D, 12'h000, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd0};
    vecs[3]  = '{8'h0A, 12'h000, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd1};
    vecs[4]  = '{8'h7E, 12'h123, 1'b1, 16'h0140, 32'h0001237E, 7'd1, 6'd1};
    vecs[5]  = '{8'h20, 12'hFFF, 1'b1, 16'h0144, 32'h000FFF20, 7'd2, 6'd1};
    vecs[6]  = '{8'h08, 12'h000, 1'b0, 16'h0000, 32'h0,        7'd1, 6'd1};
    vecs[7]  = '{8'h08, 12'h000, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd1};
    vecs[8]  = '{8'h08, 12'h000, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd1};
    vecs[9]  = '{8'h00, 12'h000, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd1};
    vecs[10] = '{8'h7F, 12'hFFF, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd1};
    vecs[11] = '{8'h0A, 12'h000, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd2};
    vecs[12] = '{8'hC1, 12'hFFF, 1'b0, 16'h0000, 32'h0,        7'd0, 6'd2};
    vecs[13] = '{8'h7E, 12'h800, 1'b1, 16'h0280, 32'h0008007E, 7'd1, 6'd2};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ready", {31'b0, CH_READY}, 32'd0);
    check("rst_busy",  {31'b0, BUSY},     32'd0);
    check("rst_curx",  {25'b0, CURX},     32'd0);
    check("rst_cury",  {26'b0, CURY},     32'd0);
    check("rst_wren",  {31'b0, WREN},     32'd0);
    check("rst_rden",  {31'b0, RDEN},     32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("rel_ready", {31'b0, CH_READY}, 32'd1);

    for (int n = 0; n < 14; n++) run_vec(vecs[n], n);

    // 80 printables wrap the row
    do_reset();
    for (int i = 0; i < 80; i++) begin
      send_char(8'h41 + 8'(i % 26), 12'h0F0);
      check($sformatf("row_addr%0d", i), {16'b0, WRADDR}, 32'(i * 4));
      @(negedge CLK);
    end
    check("wrap_last_data", mem[79], 32'h0000F041 + 32'(79 % 26));
    check("wrap_curx", {25'b0, CURX}, 32'd0);
    check("wrap_cury", {26'b0, CURY}, 32'd1);
    send_char(8'h08, 12'h000);
    check("bs_col0_curx", {25'b0, CURX}, 32'd0);
    check("bs_col0_cury", {26'b0, CURY}, 32'd1);

    // Scroll from (5,49), then again with host traffic
    do_reset();
    for (int i = 0; i < 49; i++) send_char(8'h0A, 12'h000);
    for (int i = 0; i < 5; i++) begin
      send_char(8'h20, 12'h111);
      @(negedge CLK);
    end
    check("pos_curx", {25'b0, CURX}, 32'd5);
    check("pos_cury", {26'b0, CURY}, 32'd49);
    do_fill();
    do_scroll(1'b0, 0);
    H_RDEN = 1'b1; H_RDADDR = 16'h0000;
    #1 check("host_rd_pass", {31'b0, RDEN}, 32'd1);
    @(negedge CLK);
    H_RDEN = 1'b0;
    check("host_rd_data", H_RDDATA, 32'd1);
    do_fill();
    do_scroll(1'b1, 1);

    // CLR_REQ collides with CH_VALID: clear wins, character follows
    CLR_REQ = 1'b1; CH_VALID = 1'b1; CH_DATA = 8'h5A; CH_COLOR = 12'h00F;
    #1 check("clr_ready_low", {31'b0, CH_READY}, 32'd0);
    @(negedge CLK);
    CLR_REQ = 1'b0;
    busy = 0;
    while (BUSY && busy < 10000) begin
      busy++;
      @(negedge CLK);
    end
    check("clr_cycles", busy, 4001);
    check("clr_curx", {25'b0, CURX}, 32'd0);
    check("clr_cury", {26'b0, CURY}, 32'd0);
    bad = 0;
    for (int i = 0; i < 4000; i++) if (mem[i] !== 32'h0) bad++;
    check("clr_nonzero_words", bad, 0);
    @(negedge CLK);
    CH_VALID = 1'b0;
    check("clr_char_wren", {31'b0, WREN}, 32'd1);
    check("clr_char_addr", {16'b0, WRADDR}, 32'h0);
    check("clr_char_data", WRDATA, 32'h00000F5A);
    @(negedge CLK);
    check("clr_char_curx", {25'b0, CURX}, 32'd1);

    // Reset in the middle of a scroll
    for (int i = 0; i < 49; i++) send_char(8'h0A, 12'h000);
    do_fill();
    send_char(8'h0A, 12'h000);
    k = 0;
    while (!(RDEN && RDADDR == 16'(1080 * 4)) && k < 5000) begin
      @(negedge CLK);
      k++;
    end
    check("mid_rd1000_found", {31'b0, k < 5000}, 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_wren",  {31'b0, WREN},     32'd0);
    check("mid_rden",  {31'b0, RDEN},     32'd0);
    check("mid_busy",  {31'b0, BUSY},     32'd0);
    check("mid_curx",  {25'b0, CURX},     32'd0);
    check("mid_cury",  {26'b0, CURY},     32'd0);
    check("mid_ready_in_rst", {31'b0, CH_READY}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_ready_rel", {31'b0, CH_READY}, 32'd1);
    check("mid_w999", mem[999], 32'd13);
    check("mid_w1000", mem[1000], 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
